// File: rtl/adbg_lint_downsizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adbg_lint_downsizer
//  Purpose  : Splits 64-bit debug LINT requests into one or two sequential
//             32-bit beats and merges the beat responses back into a single
//             64-bit response with a combined error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module adbg_lint_downsizer #(
  parameter int ADDR_WIDTH = 32,
  parameter int AUX_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,

  input  logic                  s_req_i,
  input  logic [ADDR_WIDTH-1:0] s_add_i,
  input  logic                  s_wen_i,
  input  logic [63:0]           s_wdata_i,
  input  logic [7:0]            s_be_i,
  input  logic [AUX_WIDTH-1:0]  s_aux_i,
  output logic                  s_gnt_o,
  output logic                  s_r_valid_o,
  output logic [63:0]           s_r_rdata_o,
  output logic                  s_r_opc_o,
  output logic [AUX_WIDTH-1:0]  s_r_aux_o,

  output logic                  m_req_o,
  output logic [ADDR_WIDTH-1:0] m_add_o,
  output logic                  m_wen_o,
  output logic [31:0]           m_wdata_o,
  output logic [3:0]            m_be_o,
  output logic [AUX_WIDTH-1:0]  m_aux_o,
  input  logic                  m_gnt_i,
  input  logic                  m_r_valid_i,
  input  logic [31:0]           m_r_rdata_i,
  input  logic                  m_r_opc_i,
  input  logic [AUX_WIDTH-1:0]  m_r_aux_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO_REQ = 3'd1,
    LO_RSP = 3'd2,
    HI_REQ = 3'd3,
    HI_RSP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-4:0] r_add_base;   // 8-byte aligned base of the request
  logic [31:0]           r_wdata_hi;   // upper write word, needed for a later HI beat
  logic [3:0]            r_be_hi;      // upper byte enables decide whether a HI beat follows
  logic [31:0]           r_rdata_lo;   // low-half read data accumulator
  logic                  r_opc;        // OR of beat errors seen so far

  logic                  w_final_req;
  logic [31:0]           w_beat_rdata;
  logic                  w_unused_add_lsb;

  // Byte offset within the 64-bit word is implied by the byte enables.
  assign w_unused_add_lsb = ^s_add_i[2:0];

  // The grant goes upstream only once the last beat of the transaction is accepted.
  assign w_final_req = (r_state == HI_REQ) || ((r_state == LO_REQ) && (r_be_hi == 4'h0));
  assign s_gnt_o     = w_final_req && m_gnt_i;

  // Write responses carry no meaningful data, so only read beats contribute.
  assign w_beat_rdata = m_wen_o ? m_r_rdata_i : 32'h0;

  // Main sequencer: beat issue, response merge and all registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_add_base  <= '0;
      r_wdata_hi  <= '0;
      r_be_hi     <= '0;
      r_rdata_lo  <= '0;
      r_opc       <= 1'b0;
      s_r_valid_o <= 1'b0;
      s_r_rdata_o <= '0;
      s_r_opc_o   <= 1'b0;
      s_r_aux_o   <= '0;
      m_req_o     <= 1'b0;
      m_add_o     <= '0;
      m_wen_o     <= 1'b0;
      m_wdata_o   <= '0;
      m_be_o      <= '0;
      m_aux_o     <= '0;
    end else begin
      s_r_valid_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (s_req_i) begin
            r_add_base <= s_add_i[ADDR_WIDTH-1:3];
            r_wdata_hi <= s_wdata_i[63:32];
            r_be_hi    <= s_be_i[7:4];
            r_rdata_lo <= '0;
            r_opc      <= 1'b0;
            m_req_o    <= 1'b1;
            m_wen_o    <= s_wen_i;
            m_aux_o    <= s_aux_i;
            // A request with no byte enables still issues one (empty) low beat.
            if ((s_be_i[3:0] != 4'h0) || (s_be_i == 8'h00)) begin
              r_state   <= LO_REQ;
              m_add_o   <= {s_add_i[ADDR_WIDTH-1:3], 3'b000};
              m_be_o    <= s_be_i[3:0];
              m_wdata_o <= s_wdata_i[31:0];
            end else begin
              r_state   <= HI_REQ;
              m_add_o   <= {s_add_i[ADDR_WIDTH-1:3], 3'b100};
              m_be_o    <= s_be_i[7:4];
              m_wdata_o <= s_wdata_i[63:32];
            end
          end
        end

        LO_REQ: begin
          if (m_gnt_i) begin
            m_req_o <= 1'b0;
            r_state <= LO_RSP;
          end
        end

        LO_RSP: begin
          if (m_r_valid_i) begin
            r_rdata_lo <= w_beat_rdata;
            r_opc      <= r_opc | m_r_opc_i;
            if (r_be_hi != 4'h0) begin
              r_state   <= HI_REQ;
              m_req_o   <= 1'b1;
              m_add_o   <= {r_add_base, 3'b100};
              m_be_o    <= r_be_hi;
              m_wdata_o <= r_wdata_hi;
            end else begin
              r_state     <= DONE;
              s_r_valid_o <= 1'b1;
              s_r_rdata_o <= {32'h0, w_beat_rdata};
              s_r_opc_o   <= r_opc | m_r_opc_i;
              s_r_aux_o   <= m_r_aux_i;
            end
          end
        end

        HI_REQ: begin
          if (m_gnt_i) begin
            m_req_o <= 1'b0;
            r_state <= HI_RSP;
          end
        end

        HI_RSP: begin
          if (m_r_valid_i) begin
            r_state     <= DONE;
            r_opc       <= r_opc | m_r_opc_i;
            s_r_valid_o <= 1'b1;
            s_r_rdata_o <= {w_beat_rdata, r_rdata_lo};
            s_r_opc_o   <= r_opc | m_r_opc_i;
            s_r_aux_o   <= m_r_aux_i;
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adbg_lint_downsizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_adbg_lint_downsizer
//  Purpose  : Self-checking bench for adbg_lint_downsizer with a downstream
//             responder model and beat/response scoreboards.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adbg_lint_downsizer;

  logic        clk_i;
  logic        rstn_i;
  logic        s_req_i;
  logic [31:0] s_add_i;
  logic        s_wen_i;
  logic [63:0] s_wdata_i;
  logic [7:0]  s_be_i;
  logic [5:0]  s_aux_i;
  logic        s_gnt_o;
  logic        s_r_valid_o;
  logic [63:0] s_r_rdata_o;
  logic        s_r_opc_o;
  logic [5:0]  s_r_aux_o;
  logic        m_req_o;
  logic [31:0] m_add_o;
  logic        m_wen_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_be_o;
  logic [5:0]  m_aux_o;
  logic        m_gnt_i;
  logic        m_r_valid_i;
  logic [31:0] m_r_rdata_i;
  logic        m_r_opc_i;
  logic [5:0]  m_r_aux_i;

  typedef struct packed {
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wen;
    logic [5:0]  aux;
    logic [31:0] rdata;
    logic        opc;
    logic [5:0]  raux;
    logic        is_last;
  } beat_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        opc;
    logic [5:0]  aux;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  adbg_lint_downsizer #(
    .ADDR_WIDTH(32),
    .AUX_WIDTH (6)
  ) u_dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .s_req_i    (s_req_i),
    .s_add_i    (s_add_i),
    .s_wen_i    (s_wen_i),
    .s_wdata_i  (s_wdata_i),
    .s_be_i     (s_be_i),
    .s_aux_i    (s_aux_i),
    .s_gnt_o    (s_gnt_o),
    .s_r_valid_o(s_r_valid_o),
    .s_r_rdata_o(s_r_rdata_o),
    .s_r_opc_o  (s_r_opc_o),
    .s_r_aux_o  (s_r_aux_o),
    .m_req_o    (m_req_o),
    .m_add_o    (m_add_o),
    .m_wen_o    (m_wen_o),
    .m_wdata_o  (m_wdata_o),
    .m_be_o     (m_be_o),
    .m_aux_o    (m_aux_o),
    .m_gnt_i    (m_gnt_i),
    .m_r_valid_i(m_r_valid_i),
    .m_r_rdata_i(m_r_rdata_i),
    .m_r_opc_i  (m_r_opc_i),
    .m_r_aux_i  (m_r_aux_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one upstream transaction while acting as the downstream slave.
  // Cycle 0 is the cycle in which s_req_i is first presented to the DUT.
  task automatic do_txn(input logic [31:0] add, input logic wen, input logic [63:0] wdata,
                        input logic [7:0] be, input logic [5:0] aux, input int gnt_wait,
                        input logic [31:0] rd_lo, input logic [31:0] rd_hi,
                        input logic opc_lo, input logic opc_hi,
                        input int exp_gnt_cyc, input int exp_vld_cyc, input bit abort_hi);
    beat_t       b;
    rsp_t        r;
    logic        has_lo;
    logic        has_hi;
    logic [31:0] base;
    bit          done;
    bit          gnt_seen;
    bit          pend;
    int          wait_cnt;
    logic [31:0] p_rdata;
    logic        p_opc;
    logic [5:0]  p_aux;

    has_lo  = (be[3:0] != 4'h0) || (be == 8'h00);
    has_hi  = (be[7:4] != 4'h0);
    base    = {add[31:3], 3'b000};
    r.rdata = '0;
    r.opc   = 1'b0;
    r.aux   = '0;
    if (has_lo) begin
      b.add = base;  b.be = be[3:0];  b.wdata = wdata[31:0];
      b.wen = wen;   b.aux = aux;     b.rdata = rd_lo;
      b.opc = opc_lo; b.raux = aux ^ 6'h15; b.is_last = !has_hi;
      beat_q.push_back(b);
      if (wen) r.rdata[31:0] = rd_lo;
      r.opc = r.opc | opc_lo;
      r.aux = b.raux;
    end
    if (has_hi) begin
      b.add = base + 32'd4; b.be = be[7:4]; b.wdata = wdata[63:32];
      b.wen = wen;   b.aux = aux;     b.rdata = rd_hi;
      b.opc = opc_hi; b.raux = aux ^ 6'h2A; b.is_last = 1'b1;
      beat_q.push_back(b);
      if (wen) r.rdata[63:32] = rd_hi;
      r.opc = r.opc | opc_hi;
      r.aux = b.raux;
    end
    rsp_q.push_back(r);

    s_req_i = 1'b1; s_add_i = add; s_wen_i = wen; s_wdata_i = wdata; s_be_i = be; s_aux_i = aux;
    done = 0; gnt_seen = 0; pend = 0; wait_cnt = 0;
    p_rdata = '0; p_opc = 1'b0; p_aux = '0;

    for (int k = 0; k < 60 && !done; k++) begin
      if (gnt_seen) s_req_i = 1'b0;
      m_r_valid_i = pend;
      m_r_rdata_i = pend ? p_rdata : 32'h0;
      m_r_opc_i   = pend & p_opc;
      m_r_aux_i   = pend ? p_aux : 6'h0;
      pend        = 0;
      m_gnt_i     = 1'b0;
      if (m_req_o) begin
        if (abort_hi && m_add_o[2]) begin
          #2 rstn_i = 1'b0;
          #1;
          check_val("rst_m_req", m_req_o, 1'b0);
          check_val("rst_s_r_valid", s_r_valid_o, 1'b0);
          check_val("rst_s_gnt", s_gnt_o, 1'b0);
          check_val("rst_m_add", m_add_o, 32'h0);
          check_val("rst_s_r_rdata", s_r_rdata_o, 64'h0);
          s_req_i = 1'b0;
          m_r_valid_i = 1'b0;
          beat_q.delete();
          rsp_q.delete();
          @(posedge clk_i); #1 rstn_i = 1'b1;
          @(posedge clk_i); #1;
          return;
        end
        if (wait_cnt >= gnt_wait) begin
          m_gnt_i = 1'b1;
        end else begin
          wait_cnt++;
          // A stray response while a request waits must be ignored.
          if (!m_r_valid_i) begin
            m_r_valid_i = 1'b1; m_r_rdata_i = 32'hBAD0BAD0; m_r_opc_i = 1'b1; m_r_aux_i = 6'h3F;
          end
        end
      end
      #4;
      if (m_req_o) begin
        if (beat_q.size() == 0) begin
          check_val("spurious_req", 1'b1, 1'b0);
        end else begin
          b = beat_q[0];
          check_val("m_add", m_add_o, b.add);
          check_val("m_be", m_be_o, b.be);
          check_val("m_wdata", m_wdata_o, b.wdata);
          check_val("m_wen", m_wen_o, b.wen);
          check_val("m_aux", m_aux_o, b.aux);
          if (m_gnt_i) begin
            check_val("s_gnt_on_grant", s_gnt_o, b.is_last);
            if (b.is_last && exp_gnt_cyc >= 0) check_val("gnt_cycle", k, exp_gnt_cyc);
            if (s_gnt_o) gnt_seen = 1;
            pend = 1; p_rdata = b.rdata; p_opc = b.opc; p_aux = b.raux;
            wait_cnt = 0;
            void'(beat_q.pop_front());
          end else begin
            check_val("s_gnt_wait", s_gnt_o, 1'b0);
          end
        end
      end
      if (s_r_valid_o) begin
        if (rsp_q.size() == 0) begin
          check_val("spurious_rsp", 1'b1, 1'b0);
        end else begin
          r = rsp_q.pop_front();
          check_val("s_r_rdata", s_r_rdata_o, r.rdata);
          check_val("s_r_opc", s_r_opc_o, r.opc);
          check_val("s_r_aux", s_r_aux_o, r.aux);
          check_val("beats_left", beat_q.size(), 0);
          if (exp_vld_cyc >= 0) check_val("vld_cycle", k, exp_vld_cyc);
        end
        done = 1;
      end
      @(posedge clk_i); #1;
    end

    s_req_i = 1'b0; m_r_valid_i = 1'b0; m_gnt_i = 1'b0;
    if (!done) begin
      check_val("timeout", 1'b0, 1'b1);
      beat_q.delete();
      rsp_q.delete();
    end else begin
      #4;
      check_val("vld_one_cycle", s_r_valid_o, 1'b0);
      check_val("rdata_hold", s_r_rdata_o, r.rdata);
      check_val("opc_hold", s_r_opc_o, r.opc);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    rstn_i = 1'b0;
    s_req_i = 1'b0; s_add_i = '0; s_wen_i = 1'b0; s_wdata_i = '0; s_be_i = '0; s_aux_i = '0;
    m_gnt_i = 1'b0; m_r_valid_i = 1'b0; m_r_rdata_i = '0; m_r_opc_i = 1'b0; m_r_aux_i = '0;
    repeat (3) @(posedge clk_i);
    #4;
    check_val("reset_m_req", m_req_o, 1'b0);
    check_val("reset_s_gnt", s_gnt_o, 1'b0);
    check_val("reset_s_r_valid", s_r_valid_o, 1'b0);
    check_val("reset_s_r_rdata", s_r_rdata_o, 64'h0);
    check_val("reset_s_r_opc", s_r_opc_o, 1'b0);
    check_val("reset_s_r_aux", s_r_aux_o, 6'h0);
    check_val("reset_m_add", m_add_o, 32'h0);
    check_val("reset_m_be", m_be_o, 4'h0);
    check_val("reset_m_wdata", m_wdata_o, 32'h0);
    @(posedge clk_i); #1 rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Single low beat read, zero-wait downstream.
    do_txn(32'h1000_0004, 1'b1, 64'h0, 8'h0F, 6'h01, 0,
           32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1, 3, 0);
    // Full 64-bit write, two beats, zero-wait.
    do_txn(32'h2000_0000, 1'b0, 64'h11223344_55667788, 8'hFF, 6'h02, 0,
           32'h0BAD_0001, 32'h0BAD_0002, 1'b0, 1'b0, 3, 5, 0);
    // High-only read with the grant held off for 4 cycles.
    do_txn(32'h3000_0008, 1'b1, 64'h0, 8'hF0, 6'h03, 4,
           32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 5, 7, 0);
    // Two-beat read, error on the low beat only.
    do_txn(32'h4000_0010, 1'b1, 64'h0, 8'hFF, 6'h04, 0,
           32'h89ABCDEF, 32'h01234567, 1'b1, 1'b0, 3, 5, 0);
    // Error on the high beat only, with a one-cycle grant delay per beat.
    do_txn(32'h5000_000C, 1'b1, 64'h0, 8'h3C, 6'h05, 1,
           32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, 5, 7, 0);
    // Zero byte-enable write issues one empty low beat.
    do_txn(32'h6000_0000, 1'b0, 64'hFFFF_0000_1234_5678, 8'h00, 6'h06, 0,
           32'h0, 32'h0, 1'b0, 1'b0, 1, 3, 0);
    // Reset while the high beat is being requested.
    do_txn(32'h7000_0000, 1'b1, 64'h0, 8'hFF, 6'h07, 0,
           32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, -1, -1, 1);
    // Normal transaction right after the abort.
    do_txn(32'h8000_0004, 1'b1, 64'h0, 8'h0F, 6'h08, 0,
           32'h7654_3210, 32'h0, 1'b0, 1'b0, 1, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adbg_lint_downsizer.md
Name: adbg_lint_downsizer

Overview:
- Sits between the debug-side 64-bit LINT master (clk_i domain) and the 32-bit SoC LINT interconnect.
- Splits each 64-bit request into one or two 32-bit beats, issued sequentially, based on which byte-enable halves are active.
- Merges the read data of those beats back into a single 64-bit response with one error flag.
- Fully in the clk_i domain; no CDC inside.

Parameters:
- ADDR_WIDTH, 32, LINT address width on both sides.
- AUX_WIDTH, 6, aux field width, passed through unchanged.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset, active-low
- s_req_i  in  1  upstream request
- s_add_i  in  ADDR_WIDTH  upstream byte address
- s_wen_i  in  1  0=write, 1=read
- s_wdata_i  in  64  write data
- s_be_i  in  8  byte enables
- s_aux_i  in  AUX_WIDTH  aux
- s_gnt_o  out  1  upstream grant
- s_r_valid_o  out  1  upstream response valid
- s_r_rdata_o  out  64  merged read data
- s_r_opc_o  out  1  merged error (1=error)
- s_r_aux_o  out  AUX_WIDTH  response aux
- m_req_o  out  1  downstream request
- m_add_o  out  ADDR_WIDTH  downstream address
- m_wen_o  out  1  downstream write-enable-n
- m_wdata_o  out  32  downstream write data
- m_be_o  out  4  downstream byte enables
- m_aux_o  out  AUX_WIDTH  downstream aux
- m_gnt_i  in  1  downstream grant
- m_r_valid_i  in  1  downstream response valid
- m_r_rdata_i  in  32  downstream read data
- m_r_opc_i  in  1  downstream error
- m_r_aux_i  in  AUX_WIDTH  downstream response aux

Behaviour:
- Clock and reset: one clock (clk_i); asynchronous active-low reset (rstn_i).
- Reset values:
  - All outputs 0; s_r_rdata_o=0.
  - FSM in IDLE; capture registers cleared.
  - Reset mid-transaction abandons the transaction; m_req_o drops immediately.
- FSM states: IDLE, LO_REQ, LO_RSP, HI_REQ, HI_RSP, DONE.
- IDLE:
  - If s_req_i=1, capture add/wen/wdata/be/aux and clear the read-data/opc accumulators.
  - Next state: LO_REQ if be[3:0]!=0 or be==0 (zero-be request sends one low beat with m_be_o=0000); otherwise HI_REQ.
- LO_REQ:
  - m_req_o=1, m_add_o={add[ADDR_WIDTH-1:3],3'b000}, m_be_o=be[3:0], m_wdata_o=wdata[31:0].
  - Hold all m_* signals until m_gnt_i; then go to LO_RSP.
- LO_RSP:
  - On m_r_valid_i: rdata_lo<=m_r_rdata_i, opc|=m_r_opc_i.
  - Next state: HI_REQ if be[7:4]!=0, else DONE.
- HI_REQ: as LO_REQ, but m_add_o={add[ADDR_WIDTH-1:3],3'b100}, m_be_o=be[7:4], m_wdata_o=wdata[63:32]; then HI_RSP on grant.
- HI_RSP: on m_r_valid_i, rdata_hi<=m_r_rdata_i, opc|=m_r_opc_i; go to DONE.
- DONE: s_r_valid_o=1 for exactly one cycle; go to IDLE.
- Common to all beats:
  - m_wen_o and m_aux_o equal the captured values.
  - Reads and writes follow the same flow; write responses are consumed but their data is discarded.
  - At most one outstanding beat; HI beat is issued only after the LO response arrives.
- s_gnt_o: combinational, =1 only in the cycle where the final beat of the transaction sees m_gnt_i.
- Upstream contract: holds s_req_i and its payload stable until s_gnt_o. The upstream request is not re-captured until the FSM is back in IDLE.
- Response outputs (all registered and held stable until the next DONE):
  - s_r_rdata_o={rdata_hi,rdata_lo}; the unaccessed half is 0.
  - s_r_opc_o = OR of the beat errors.
  - s_r_aux_o = aux of the final beat.
- Ignored inputs:
  - m_r_valid_i outside LO_RSP/HI_RSP is ignored.
  - s_req_i outside IDLE is ignored.
- Latency, zero-wait downstream (gnt in the request cycle, r_valid the next cycle):
  - Single beat: s_req_i seen at cycle 0 → m_req_o at cycle 1 → s_r_valid_o at cycle 3.
  - Two beats: s_r_valid_o at cycle 5.
- Minimum gap between transactions: IDLE is visited for at least one cycle between them.

Test Plan:
- Read, be=8'h0F, add=0x1000_0004, downstream returns 0xDEADBEEF, gnt/r_valid immediate → one beat at m_add_o=0x1000_0000, m_be_o=4'hF; s_gnt_o at cycle 1; s_r_valid_o at cycle 3 with rdata=0x00000000_DEADBEEF, opc=0.
- Write, be=8'hFF, wdata=0x11223344_55667788, add=0x2000_0000 → beat1 at 0x2000_0000 with wdata 0x55667788, beat2 at 0x2000_0004 with wdata 0x11223344; s_gnt_o only on beat2's grant; s_r_valid_o one cycle after beat2's r_valid.
- Read, be=8'hF0, m_gnt_i held low 4 cycles → only HI beat issued (m_add_o=base+4); m_* stable while waiting; rdata=0xCAFEF00D_00000000.
- Read, be=8'hFF, LO beat returns opc=1, HI beat opc=0 → s_r_opc_o=1; both halves of data merged.
- be=8'h00 write → single LO beat with m_be_o=0; normal completion.
- rstn_i asserted while in HI_REQ → m_req_o=0 and s_r_valid_o=0 immediately; FSM in IDLE; the next request completes normally.
